dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory target that answers load/store requests issued by the core's memory stage.
- Single-ported doubleword array behind a valid/ready request channel and a valid/ready response channel.
- Handles byte/half/word/double access sizes, sign or zero extension on loads, byte-masked stores, and programmable wait states.
- Flags misaligned or out-of-range accesses with an error response instead of touching memory.

Parameters:
- DEPTH, 512: number of 64-bit doublewords in the array; power of two, ≥2.
- LATENCY, 1: wait-state cycles between request acceptance and response valid; 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  64  store data; low bytes used per size.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Only one request may be outstanding at a time.
- State machine:
  - IDLE: req_ready=1. On req_valid, latch all request fields and the error flag, load the wait counter with LATENCY, and go to WAIT; if LATENCY=0, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle; when it reaches 1, go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- Latency: for a request accepted at edge N, resp_valid rises after edge N+1+LATENCY.
- req_ready is low in WAIT and RESP. A new request can be accepted no earlier than the cycle after the response handshake.
- Response hold: resp_rdata and resp_err are registered on entry to RESP. They stay stable while resp_valid=1 and resp_ready=0.
- Word index is req_addr[3 +: log2(DEPTH)]; the byte lane is req_addr[2:0].
- Out of range: any address bit at or above 3+log2(DEPTH) is set.
- Misaligned:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - double with addr[2:0]≠0.
- Error handling: resp_err=1 and resp_rdata=0. Memory is not written.
- Load data: extract the selected lane(s). Extend from bit 7/15/31 per req_unsigned. A double load returns the full doubleword and ignores req_unsigned.
- Store commit: the write is performed on the edge that enters RESP. Only the byte-enabled lanes change; the other bytes of the doubleword are preserved.
- Store response: resp_rdata=0 and resp_err=0.
- A load that follows a store reads the stored data, because the write has committed before the next acceptance.
- Reset:
  - state=IDLE; req_ready=1 in the first cycle after reset.
  - resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - Array contents are not cleared.
- Reset during WAIT aborts the operation. A pending store is not written.
- resp_ready asserted while resp_valid=0 is ignored.
- Request inputs are ignored outside IDLE.

Decomposition:
- Shared package dmem_pkg holds:
  - mem_size_e (SZ_B, SZ_H, SZ_W, SZ_D);
  - resp_state_e (IDLE, WAIT, RESP);
  - the function byte_mask(size, offset) returning an 8-bit lane mask.
- One combinational sub-module, lsu_align, is natural. It takes size, offset, unsigned, raw doubleword and store data. It produces the extended load data, the merged store doubleword, and the misaligned flag.

Test Plan:
- Store then load, LATENCY=1:
  - Stimulus: store D 0x1122334455667788 at 0x40, then load D at 0x40.
  - Required: rdata 0x1122334455667788, err=0; resp_valid exactly 2 cycles after each acceptance.
- Signed/unsigned extension:
  - Stimulus: store B 0x80 at 0x43; load B signed at 0x43; load B unsigned at 0x43.
  - Required: signed → 0xFFFFFFFFFFFFFF80; unsigned → 0x0000000000000080; the other bytes at 0x40 are unchanged from the prior store.
- Misaligned:
  - Stimulus: load W at 0x42, then store H 0xBEEF at 0x41.
  - Required: both responses have err=1 and rdata=0; a subsequent load D at 0x40 is unchanged.
- Out of range:
  - Stimulus: with DEPTH=512, load at 0x1000.
  - Required: err=1, rdata=0.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles after resp_valid rises.
  - Required: resp_rdata and resp_err stable throughout; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
- Reset mid-operation:
  - Stimulus: LATENCY=4; store D 0xDEAD at 0x80; assert rst during WAIT; then load D at 0x80.
  - Required: resp_valid=0 and req_ready=1 after reset; the load returns the old contents, not 0xDEAD.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NBYTE = XLEN / 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } resp_state_e;

    // Request fields captured at acceptance.
    typedef struct packed {
        logic            we;
        mem_size_e       size;
        logic            is_unsigned;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [NBYTE-1:0] byte_mask(input mem_size_e size, input logic [2:0] offset);
        logic [NBYTE-1:0] m;
        case (size)
            SZ_B:    m = 8'(8'h01 << offset);
            SZ_H:    m = 8'(8'h03 << offset);
            SZ_W:    m = 8'(8'h0F << offset);
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Natural alignment check; bytes are always aligned.
    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] offset);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = offset[0];
            SZ_W:    r = |offset[1:0];
            default: r = |offset;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction / extension for loads, byte merge for stores, alignment check.
module lsu_align
    import dmem_pkg::*;
(
    input  mem_size_e        size,
    input  logic [2:0]       offset,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  raw,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data_c,
    output logic [XLEN-1:0]  store_data_c,
    output logic             misaligned_c
);

    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  wshift;
    logic [XLEN-1:0]  bit_mask;
    logic [NBYTE-1:0] lane_mask;

    // Align the selected lanes to bit 0 and extend; place store data into its lanes.
    always_comb begin
        shifted   = raw >> {offset, 3'b000};
        wshift    = wdata << {offset, 3'b000};
        lane_mask = byte_mask(size, offset);
        bit_mask  = '0;
        for (int i = 0; i < int'(NBYTE); i++) begin
            bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
        end

        case (size)
            SZ_B:    load_data_c = is_unsigned ? {56'd0, shifted[7:0]}
                                               : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data_c = is_unsigned ? {48'd0, shifted[15:0]}
                                               : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_data_c = is_unsigned ? {32'd0, shifted[31:0]}
                                               : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data_c = raw;
        endcase

        store_data_c = (raw & ~bit_mask) | (wshift & bit_mask);
        misaligned_c = is_misaligned(size, offset);
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    resp_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    mem_req_t        req_q, req_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem_q [DEPTH];

    mem_req_t        req_in_c;
    mem_req_t        cur_c;
    logic [AW-1:0]   idx_c;
    logic [XLEN-1:0] raw_c;
    logic            oor_c;
    logic            err_c;
    logic            enter_resp_c;
    logic            mem_we_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] store_data_c;
    logic            misaligned_c;

    // Live request while idle (zero-latency path), captured request otherwise.
    always_comb begin
        req_in_c = '{we:          req_we,
                     size:        mem_size_e'(req_size),
                     is_unsigned: req_unsigned,
                     addr:        req_addr,
                     wdata:       req_wdata};
        cur_c    = (state_q == IDLE) ? req_in_c : req_q;
        idx_c    = cur_c.addr[3 +: AW];
        raw_c    = mem_q[idx_c];
        oor_c    = (cur_c.addr >> (3 + AW)) != '0;
        err_c    = oor_c | misaligned_c;
    end

    lsu_align u_align (
        .size         (cur_c.size),
        .offset       (cur_c.addr[2:0]),
        .is_unsigned  (cur_c.is_unsigned),
        .raw          (raw_c),
        .wdata        (cur_c.wdata),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c),
        .misaligned_c (misaligned_c)
    );

    // Next-state, wait counter, response capture and store commit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_we_c     = 1'b0;
        enter_resp_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d   = req_in_c;
                    cnt_d   = CW'(LATENCY);
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        enter_resp_c = (state_d == RESP) && (state_q != RESP);
        if (enter_resp_c) begin
            err_d    = err_c;
            rdata_d  = (cur_c.we || err_c) ? '0 : load_data_c;
            mem_we_c = cur_c.we && !err_c;
        end

        resp_valid_d = (state_q == RESP) && !(resp_valid_q && resp_ready);
        req_ready_d  = (state_d == IDLE);
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Storage array; contents survive reset, writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem_q[idx_c] <= store_data_c;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
